// File: rtl/inst_rom_resp_pkg.sv
// ----------------------------------------------------------------------------
// inst_rom_resp_pkg
//   Shared definitions for the instruction-memory responder:
//     INST_W / NOP            instruction width and the value returned when
//                             no valid instruction is presented
//     state_t                 responder FSM encoding (IDLE / BUSY)
//     fsm_t                   packed FSM state + wait counter; this is the
//                             single place a checker binds to observe the FSM
//     CHIP_ENABLE/DISABLE     polarity of the fetch enable from the PC gen
//     pc_misaligned()         pc not on a 32-bit word boundary
//     pc_out_of_range()       pc above the implemented memory depth
// ----------------------------------------------------------------------------
package inst_rom_resp_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP = 32'h0;

  // Wait counter width; holds WAIT_STATES up to 7.
  localparam int CNT_W = 3;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    state_t           state;
    logic [CNT_W-1:0] count;
  } fsm_t;

  function automatic logic pc_misaligned(input logic [31:0] pc);
    return (pc[1:0] != 2'b00);
  endfunction

  // Any address bit at or above (addr_w + 2) lies beyond the word array.
  function automatic logic pc_out_of_range(input logic [31:0] pc,
                                           input int          addr_w);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i >= addr_w + 2) r = r | pc[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/inst_rom_resp_array.sv
// ----------------------------------------------------------------------------
// inst_rom_array
//   Word RAM holding the program image. One synchronous write port and one
//   synchronous read port sharing the same clock. A read and a write to the
//   same word at the same edge return the previous contents (read-before-
//   write), which falls out of both updates being non-blocking.
//   Ports:
//     clk      clock
//     wr_en    write strobe
//     wr_addr  word index to write
//     wr_data  data to write
//     rd_en    read strobe; rd_data only changes when this is high
//     rd_addr  word index to read
//     rd_data  registered read data
//   The array has no reset: program contents survive a core reset.
// ----------------------------------------------------------------------------
module inst_rom_array
  import inst_rom_resp_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/inst_rom_resp.sv
// ----------------------------------------------------------------------------
// inst_rom_resp
//   Fetch-stage instruction responder. Accepts a byte fetch address from the
//   PC generator and returns the addressed 32-bit word after 1 + WAIT_STATES
//   cycles, raising stallreq while the PC must hold.
//   Ports:
//     clk         clock
//     rst         asynchronous reset, active low
//     ce          fetch enable (CHIP_ENABLE = fetch)
//     pc          byte fetch address
//     flush       abort any in-flight fetch
//     wr_en       program-load write strobe
//     wr_addr     word index for the load write
//     wr_data     load write data
//     inst        returned instruction, NOP when nothing valid
//     inst_valid  one-cycle pulse per completed fetch
//     stallreq    combinational stall request to the pipeline controller
//     addr_err    returned fetch was misaligned or out of range
//   Handshake: a fetch is accepted in any IDLE cycle with ce high and flush
//   low; the PC generator must keep offering it (holding the PC) for as long
//   as stallreq is high. The result appears with inst_valid in the cycle after
//   the last accepted/wait cycle and is not back-pressured.
//   WAIT_STATES must be 0..7 (it is loaded into a 3-bit counter).
// ----------------------------------------------------------------------------
module inst_rom_resp
  import inst_rom_resp_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [31:0]       pc,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic              stallreq,
  output logic              addr_err
);

  fsm_t              fsm_q;
  logic [31:0]       pc_q;
  logic              valid_q;
  logic              err_q;

  logic              accept;
  logic              busy_done;
  logic              complete;
  logic [31:0]       rd_pc;
  logic              rd_err;
  logic [ADDR_W-1:0] rd_addr;
  logic [INST_W-1:0] rd_data;

  always_comb begin
    accept    = (fsm_q.state == IDLE) && (ce == CHIP_ENABLE) && !flush;
    busy_done = (fsm_q.state == BUSY) && (fsm_q.count == 3'd1) && !flush;
    // Zero wait states: the fetch completes at the edge it is accepted.
    complete  = (WAIT_STATES == 0) ? accept : busy_done;
    // In IDLE the live pc is read; in BUSY the address latched at accept.
    rd_pc     = (fsm_q.state == IDLE) ? pc : pc_q;
    rd_addr   = rd_pc[ADDR_W+1:2];
    rd_err    = pc_misaligned(rd_pc) | pc_out_of_range(rd_pc, ADDR_W);
    // Flush always wins, so no stall is requested in a flush cycle.
    stallreq  = !flush &&
                (((fsm_q.state == IDLE) && (ce == CHIP_ENABLE) && (WAIT_STATES != 0)) ||
                 ((fsm_q.state == BUSY) && (fsm_q.count > 3'd1)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q   <= '{state: IDLE, count: '0};
      pc_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (flush) begin
      fsm_q   <= '{state: IDLE, count: '0};
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= complete;
      err_q   <= complete & rd_err;
      if (accept) pc_q <= pc;
      case (fsm_q.state)
        IDLE: begin
          if (accept && (WAIT_STATES != 0)) begin
            fsm_q.state <= BUSY;
            fsm_q.count <= CNT_W'(WAIT_STATES);
          end
        end
        BUSY: begin
          fsm_q.count <= fsm_q.count - 3'd1;
          if (fsm_q.count == 3'd1) fsm_q.state <= IDLE;
        end
        default: fsm_q <= '{state: IDLE, count: '0};
      endcase
    end
  end

  inst_rom_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (complete),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // rd_data only changes on a completing read, so it is stable for the whole
  // cycle in which valid_q reports that read.
  assign inst       = (valid_q && !err_q) ? rd_data : NOP;
  assign inst_valid = valid_q;
  assign addr_err   = err_q;

endmodule

// File: tb/tb_inst_rom_resp.sv
module tb_inst_rom_resp;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic        flush;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;

  logic [31:0] inst_a  [3];
  logic        valid_a [3];
  logic        stall_a [3];
  logic        err_a   [3];

  int n_vec = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs: 0, 2 and 3 wait states ----------------
  inst_rom_resp #(.ADDR_W(10), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inst(inst_a[0]), .inst_valid(valid_a[0]), .stallreq(stall_a[0]), .addr_err(err_a[0]));

  inst_rom_resp #(.ADDR_W(10), .WAIT_STATES(2)) u_w2 (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inst(inst_a[1]), .inst_valid(valid_a[1]), .stallreq(stall_a[1]), .addr_err(err_a[1]));

  inst_rom_resp #(.ADDR_W(10), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .rst(rst), .ce(ce), .pc(pc), .flush(flush),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .inst(inst_a[2]), .inst_valid(valid_a[2]), .stallreq(stall_a[2]), .addr_err(err_a[2]));

  // ---------------- reference model ----------------
  // Each responder is modelled as "cycles left until the pending fetch
  // returns"; the memory is a plain array updated after reads each edge.
  int          ws [3] = '{0, 2, 3};
  int          left [3];
  logic [31:0] pend [3];
  logic [31:0] e_inst [3];
  logic        e_valid [3];
  logic        e_err [3];
  logic [31:0] mem_m [1024];

  function automatic logic bad_pc(input logic [31:0] p);
    return (p[1:0] != 2'b00) || (p[31:12] != 20'h0);
  endfunction

  function automatic logic exp_stall(input int k);
    return !flush && ((left[k] == 0 && ce && ws[k] != 0) || left[k] > 1);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      left[k] = 0; e_inst[k] = 32'h0; e_valid[k] = 1'b0; e_err[k] = 1'b0;
    end
  endtask

  task automatic finish_fetch(input int k, input logic [31:0] p);
    logic [9:0] idx;
    idx = p[11:2];
    e_valid[k] = 1'b1;
    e_err[k]   = bad_pc(p);
    e_inst[k]  = bad_pc(p) ? 32'h0 : mem_m[idx];
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      e_inst[k] = 32'h0; e_valid[k] = 1'b0; e_err[k] = 1'b0;
      if (!rst || flush) begin
        left[k] = 0;
      end else if (left[k] == 0) begin
        if (ce) begin
          if (ws[k] == 0) finish_fetch(k, pc);
          else begin
            left[k] = ws[k];
            pend[k] = pc;
          end
        end
      end else if (left[k] == 1) begin
        finish_fetch(k, pend[k]);
        left[k] = 0;
      end else begin
        left[k] = left[k] - 1;
      end
    end
    if (wr_en) mem_m[wr_addr] = wr_data;
  endtask

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s w%0d observed=%h expected=%h", tag, ws[k], obs, exp);
    end
  endtask

  task automatic chk_outputs();
    for (int k = 0; k < 3; k++) begin
      chk("inst", k, inst_a[k], e_inst[k]);
      chk("inst_valid", k, {31'h0, valid_a[k]}, {31'h0, e_valid[k]});
      chk("addr_err", k, {31'h0, err_a[k]}, {31'h0, e_err[k]});
    end
  endtask

  // ---------------- driver ----------------
  // Entered just after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic c, input logic [31:0] p, input logic f,
                       input logic we, input logic [9:0] wa, input logic [31:0] wd);
    ce = c; pc = p; flush = f; wr_en = we; wr_addr = wa; wr_data = wd;
    #1;
    for (int k = 0; k < 3; k++)
      chk("stallreq", k, {31'h0, stall_a[k]}, {31'h0, exp_stall(k)});
    model_edge();
    @(posedge clk);
    #1;
    chk_outputs();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] p);
    cycle(1'b1, p, 1'b0, 1'b0, 10'h0, 32'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, $urandom(), 1'b0, 1'b0, 10'h0, 32'h0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] p;
    logic [31:0] d;
    int          a;

    ce = 1'b0; pc = 32'h0; flush = 1'b0; wr_en = 1'b0; wr_addr = 10'h0; wr_data = 32'h0;
    rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    #1;
    // Reset state
    chk_outputs();
    for (int k = 0; k < 3; k++)
      chk("reset_stallreq", k, {31'h0, stall_a[k]}, 32'h0);

    // Program load while held in reset
    @(negedge clk);
    for (int i = 0; i < 1024; i++) begin
      case (i)
        0: d = 32'd11;
        1: d = 32'd22;
        2: d = 32'd33;
        3: d = 32'd44;
        default: d = $urandom();
      endcase
      cycle(1'b0, 32'h0, 1'b0, 1'b1, 10'(i), d);
    end
    rst = 1'b1;

    // Single-cycle reads
    fetch(32'h0);  chk("w0_read0", 0, inst_a[0], 32'd11);
    fetch(32'h4);  chk("w0_read1", 0, inst_a[0], 32'd22);
    fetch(32'h8);  chk("w0_read2", 0, inst_a[0], 32'd33);
    fetch(32'hC);  chk("w0_read3", 0, inst_a[0], 32'd44);
    chk("w0_valid_steady", 0, {31'h0, valid_a[0]}, 32'h1);
    idle(4);

    // Wait states: pc changes after the accept must be ignored
    fetch(32'h4);
    cycle(1'b0, 32'h8, 1'b0, 1'b0, 10'h0, 32'h0);
    cycle(1'b1, 32'hC, 1'b0, 1'b0, 10'h0, 32'h0);
    chk("w2_inst", 1, inst_a[1], 32'd22);
    chk("w2_valid", 1, {31'h0, valid_a[1]}, 32'h1);
    idle(5);

    // Flush in the second BUSY cycle of the 3-wait-state responder
    fetch(32'h8);
    idle(1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 10'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("w3_flushed_valid", 2, {31'h0, valid_a[2]}, 32'h0);
    end

    // Misaligned and out-of-range fetches
    fetch(32'h2);
    chk("w0_misalign_err", 0, {31'h0, err_a[0]}, 32'h1);
    chk("w0_misalign_inst", 0, inst_a[0], 32'h0);
    fetch(32'h1000);
    chk("w0_range_err", 0, {31'h0, err_a[0]}, 32'h1);
    chk("w0_range_valid", 0, {31'h0, valid_a[0]}, 32'h1);
    idle(5);

    // Read/write collision on the same word
    cycle(1'b1, 32'h4, 1'b0, 1'b1, 10'd1, 32'd55);
    chk("collide_old", 0, inst_a[0], 32'd22);
    fetch(32'h4);
    chk("collide_new", 0, inst_a[0], 32'd55);
    idle(5);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      a = $urandom_range(0, 1023);
      case ($urandom_range(0, 9))
        0:       p = $urandom();
        1:       p = 32'(a * 4) | 32'($urandom_range(1, 3));
        2:       p = 32'h1000 + 32'(a * 4);
        default: p = 32'(a * 4);
      endcase
      cycle(($urandom_range(0, 9) < 7), p, ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 7) == 0), 10'($urandom_range(0, 1023)), $urandom());
    end
    idle(5);

    // Asynchronous reset while BUSY
    fetch(32'h8);
    ce = 1'b0;
    #1;
    chk("pre_reset_stall", 1, {31'h0, stall_a[1]}, 32'h1);
    chk("pre_reset_valid", 0, {31'h0, valid_a[0]}, 32'h1);
    rst = 1'b0;
    #1;
    model_reset();
    chk_outputs();
    for (int k = 0; k < 3; k++)
      chk("async_rst_stallreq", k, {31'h0, stall_a[k]}, 32'h0);
    idle(2);
    rst = 1'b1;
    fetch(32'h8);
    chk("retained_mem", 0, inst_a[0], mem_m[2]);
    idle(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
